// File: rtl/nonlin_pkg.sv
// Shared encodings, step latencies and op decode for the nonlinear sequencing unit.
package nonlin_pkg;

   typedef enum logic [1:0] {
      OP_EXP     = 2'd0,
      OP_GELU    = 2'd1,
      OP_REQUANT = 2'd2,
      OP_RSVD    = 2'd3
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam int unsigned LAT_EXP     = 8;
   localparam int unsigned LAT_GELU    = 6;
   localparam int unsigned LAT_REQUANT = 4;
   localparam int unsigned LAT_ILLEGAL = 1;
   localparam int          STEP_W      = 3;

   // op=1 without the gelu datapath is folded into the illegal op at accept time
   function automatic op_e map_op(input logic [1:0] op, input bit gelu_en);
      if (op == 2'd1 && !gelu_en) return OP_RSVD;
      return op_e'(op);
   endfunction

   function automatic logic [STEP_W-1:0] last_step(input op_e op);
      case (op)
         OP_EXP:     return STEP_W'(LAT_EXP - 1);
         OP_GELU:    return STEP_W'(LAT_GELU - 1);
         OP_REQUANT: return STEP_W'(LAT_REQUANT - 1);
         default:    return STEP_W'(LAT_ILLEGAL - 1);
      endcase
   endfunction

endpackage

// File: rtl/nonlin_mul.sv
// Registered signed multiplier returning the low DW bits of the product one cycle later.
module nonlin_mul #(
   parameter int DW = 64
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic signed [DW-1:0] i_a,
   input  logic signed [DW-1:0] i_b,
   output logic signed [DW-1:0] o_p
);

   logic signed [DW-1:0] r_p;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) r_p <= '0;
      else          r_p <= i_a * i_b;
   end

   assign o_p = r_p;

endmodule

// File: rtl/nonlin_seq_unit.sv
// Sequenced exp / gelu / requant unit built around one shared registered multiplier.
// Define NONLIN_GELU_EN to build the gelu datapath; otherwise op=1 completes as illegal.
module nonlin_seq_unit
   import nonlin_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int FP_BITS = 30
) (
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [1:0]              op,
   input  logic signed [WIDTH-1:0] qin,
   input  logic signed [WIDTH-1:0] qb,
   input  logic signed [WIDTH-1:0] qc,
   input  logic signed [WIDTH-1:0] q1,
   input  logic signed [WIDTH-1:0] qln2,
   input  logic signed [WIDTH-1:0] qln2_inv,
   input  logic signed [WIDTH-1:0] m,
   input  logic signed [WIDTH-1:0] bias,
   input  logic [7:0]              shift,
   input  logic [5:0]              out_bits,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [WIDTH-1:0] qout,
   output logic                    err
);

   localparam int D   = 2 * WIDTH;
   localparam int SHW = $clog2(D);
   localparam logic [7:0]          FPS   = 8'(FP_BITS);
   localparam logic signed [D-1:0] Z_LIM = D'(D - 1);
`ifdef NONLIN_GELU_EN
   localparam bit GELU_EN = 1'b1;
`else
   localparam bit GELU_EN = 1'b0;
`endif

   state_e                  r_state;
   logic [STEP_W-1:0]       r_step;
   logic                    r_iready, r_ovalid, r_err;
   logic signed [WIDTH-1:0] r_qout, r_res;
   op_e                     r_op;
   logic signed [WIDTH-1:0] r_qin, r_qb, r_qc, r_q1, r_ln2, r_ln2i, r_m, r_bias;
   logic [7:0]              r_shift;
   logic [5:0]              r_obits;
   logic signed [D-1:0]     r_z;

   logic                    w_accept;
   logic signed [D-1:0]     w_p, w_ma, w_mb;
   logic signed [D-1:0]     w_qin, w_qb, w_qc, w_q1, w_ln2, w_ln2i, w_m, w_bias;
   logic signed [D-1:0]     w_z_now, w_x_sq, w_sq_in, w_poly;
   logic signed [WIDTH-1:0] w_x_res, w_rq_res, w_res_d;
   logic signed [D-1:0]     w_rq_t, w_omax, w_omin;
   int                      w_ob;
   logic                    w_res_we, w_z_we;

   function automatic logic signed [D-1:0] sx(input logic signed [WIDTH-1:0] v);
      return {{WIDTH{v[WIDTH-1]}}, v};
   endfunction

   // Oversized shifts saturate to the sign fill instead of wrapping the amount
   function automatic logic signed [D-1:0] ashr(input logic signed [D-1:0] v, input logic [7:0] sh);
      if (32'(sh) >= D) return {D{v[D-1]}};
      return v >>> sh;
   endfunction

   assign w_accept = in_valid && r_iready;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_op    <= OP_EXP;
         r_qin   <= '0;
         r_qb    <= '0;
         r_qc    <= '0;
         r_q1    <= '0;
         r_ln2   <= '0;
         r_ln2i  <= '0;
         r_m     <= '0;
         r_bias  <= '0;
         r_shift <= '0;
         r_obits <= '0;
      end else if (w_accept) begin
         r_op    <= map_op(op, GELU_EN);
         r_qin   <= qin;
         r_qb    <= qb;
         r_qc    <= qc;
         r_q1    <= q1;
         r_ln2   <= qln2;
         r_ln2i  <= qln2_inv;
         r_m     <= m;
         r_bias  <= bias;
         r_shift <= shift;
         r_obits <= out_bits;
      end
   end

   assign w_qin  = sx(r_qin);
   assign w_qb   = sx(r_qb);
   assign w_qc   = sx(r_qc);
   assign w_q1   = sx(r_q1);
   assign w_ln2  = sx(r_ln2);
   assign w_ln2i = sx(r_ln2i);
   assign w_m    = sx(r_m);
   assign w_bias = sx(r_bias);

   nonlin_mul #(.DW(D)) u_mul (
      .clock   (clock),
      .reset_n (reset_n),
      .i_a     (w_ma),
      .i_b     (w_mb),
      .o_p     (w_p)
   );

   // exp: z from the ln2_inv product, then r + qb with r = qin + z*qln2
   assign w_z_now = ashr(w_p, FPS);
   assign w_x_sq  = w_qin + w_p + w_qb;
   assign w_poly  = w_p + w_qc;
   // a negative z is outside the defined shift range and is treated like an oversized one
   assign w_x_res = (r_z[D-1] || r_z >= Z_LIM) ? '0 : WIDTH'(w_poly >>> r_z[SHW-1:0]);

`ifdef NONLIN_GELU_EN
   logic signed [D-1:0] w_abs, w_nqb, w_a, w_g_sq, w_e, w_gm;
   assign w_abs   = w_qin[D-1] ? -w_qin : w_qin;
   assign w_nqb   = -w_qb;
   assign w_a     = (w_abs < w_nqb) ? w_abs : w_nqb;
   assign w_g_sq  = w_a + w_qb;
   assign w_e     = (w_qin == '0) ? '0 : (w_qin[D-1] ? -w_poly : w_poly);
   assign w_gm    = w_e + w_q1;
   assign w_sq_in = (r_op == OP_GELU) ? w_g_sq : w_x_sq;
`else
   logic w_unused_q1;
   assign w_unused_q1 = ^w_q1;
   assign w_sq_in     = w_x_sq;
`endif

   // requant: out_bits outside 2..WIDTH is clamped into that range
   always_comb begin
      w_ob = 32'(r_obits);
      if (w_ob < 2)          w_ob = 2;
      else if (w_ob > WIDTH) w_ob = WIDTH;
      w_omax = (D'(1) <<< (w_ob - 1)) - D'(1);
      w_omin = ~w_omax;
      w_rq_t = ashr(w_p, r_shift) + w_bias;
      if (w_rq_t > w_omax)      w_rq_res = WIDTH'(w_omax);
      else if (w_rq_t < w_omin) w_rq_res = WIDTH'(w_omin);
      else                      w_rq_res = WIDTH'(w_rq_t);
   end

   always_comb begin
      w_ma     = '0;
      w_mb     = '0;
      w_res_we = 1'b0;
      w_res_d  = '0;
      w_z_we   = 1'b0;
      if (r_state == ST_BUSY) begin
         case (r_op)
            OP_EXP: begin
               case (r_step)
                  3'd0: begin w_ma = -w_qin;   w_mb = w_ln2i; end
                  3'd1: begin w_ma = w_z_now;  w_mb = w_ln2;  w_z_we = 1'b1; end
                  3'd2: begin w_ma = w_sq_in;  w_mb = w_sq_in; end
                  3'd3: begin w_res_d = w_x_res; w_res_we = 1'b1; end
                  default: ;
               endcase
            end
`ifdef NONLIN_GELU_EN
            OP_GELU: begin
               case (r_step)
                  3'd0: begin w_ma = w_sq_in; w_mb = w_sq_in; end
                  3'd1: begin w_ma = w_qin;   w_mb = w_gm; end
                  3'd2: begin w_res_d = WIDTH'(ashr(w_p, r_shift)); w_res_we = 1'b1; end
                  default: ;
               endcase
            end
`endif
            OP_REQUANT: begin
               case (r_step)
                  3'd0: begin w_ma = w_qin; w_mb = w_m; end
                  3'd1: begin w_res_d = w_rq_res; w_res_we = 1'b1; end
                  default: ;
               endcase
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_res <= '0;
         r_z   <= '0;
      end else begin
         if (w_res_we) r_res <= w_res_d;
         if (w_z_we)   r_z   <= w_z_now;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= ST_IDLE;
         r_step   <= '0;
         r_iready <= 1'b0;
         r_ovalid <= 1'b0;
         r_qout   <= '0;
         r_err    <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_iready <= 1'b1;
               if (w_accept) begin
                  r_state  <= ST_BUSY;
                  r_step   <= '0;
                  r_iready <= 1'b0;
               end
            end
            ST_BUSY: begin
               if (r_step == last_step(r_op)) begin
                  r_state  <= ST_DONE;
                  r_ovalid <= 1'b1;
                  r_err    <= (r_op == OP_RSVD);
                  r_qout   <= (r_op == OP_RSVD) ? '0 : r_res;
               end else begin
                  r_step <= r_step + 1'b1;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  r_state  <= ST_IDLE;
                  r_ovalid <= 1'b0;
                  r_qout   <= '0;
                  r_err    <= 1'b0;
                  r_iready <= 1'b1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign in_ready  = r_iready;
   assign out_valid = r_ovalid;
   assign qout      = r_qout;
   assign err       = r_err;

endmodule

// File: tb/tb_nonlin_seq_unit.sv
// Randomised self-checking bench for nonlin_seq_unit against a plain-arithmetic reference model.
module tb_nonlin_seq_unit;

   localparam int W   = 32;
   localparam int FPB = 30;

   logic                clock = 1'b0;
   logic                reset_n = 1'b1;
   logic                in_valid = 1'b0;
   logic                in_ready;
   logic [1:0]          op = '0;
   logic signed [W-1:0] qin = '0, qb = '0, qc = '0, q1 = '0;
   logic signed [W-1:0] qln2 = '0, qln2_inv = '0, m = '0, bias = '0;
   logic [7:0]          shift = '0;
   logic [5:0]          out_bits = 6'd8;
   logic                out_valid;
   logic                out_ready = 1'b0;
   logic signed [W-1:0] qout;
   logic                err;

   int n_chk = 0;
   int n_err = 0;

   always #5 clock = ~clock;

   nonlin_seq_unit #(.WIDTH(W), .FP_BITS(FPB)) dut (
      .clock    (clock),
      .reset_n  (reset_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .op       (op),
      .qin      (qin),
      .qb       (qb),
      .qc       (qc),
      .q1       (q1),
      .qln2     (qln2),
      .qln2_inv (qln2_inv),
      .m        (m),
      .bias     (bias),
      .shift    (shift),
      .out_bits (out_bits),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .qout     (qout),
      .err      (err)
   );

   task automatic chk(input string tag, input longint got, input longint exp);
      n_chk++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   function automatic longint sra(input longint v, input longint sh);
      if (sh >= 64) return (v < 0) ? -1 : 0;
      return v >>> sh;
   endfunction

   // Reference: 64-bit wrapping arithmetic, results truncated to 32 bits except requant
   function automatic void model(input logic [1:0] o, input longint x, c_qb, c_qc, c_q1,
                                 input longint c_ln2, c_ln2i, c_m, c_bias, input int sh, ob,
                                 output longint res, output longint e, output int lat);
      longint z, r, p, s, a, t, hi, lo;
      res = 0;
      e   = 0;
      lat = 1;
      case (o)
         2'd0: begin
            z = sra(-x * c_ln2i, FPB);
            r = x + z * c_ln2;
            p = (r + c_qb) * (r + c_qb) + c_qc;
            res = (z < 0 || z >= 63) ? 0 : int'(p >>> z);
            lat = 8;
         end
`ifdef NONLIN_GELU_EN
         2'd1: begin
            s = (x > 0) ? 1 : ((x < 0) ? -1 : 0);
            a = (x < 0) ? -x : x;
            if (a > -c_qb) a = -c_qb;
            res = int'(sra(x * (s * ((a + c_qb) * (a + c_qb) + c_qc) + c_q1), sh));
            lat = 6;
         end
`endif
         2'd2: begin
            t  = sra(x * c_m, sh) + c_bias;
            hi = (longint'(1) <<< (ob - 1)) - 1;
            lo = -hi - 1;
            res = (t > hi) ? hi : ((t < lo) ? lo : t);
            lat = 4;
         end
         default: begin
            res = 0;
            e   = 1;
            lat = 1;
         end
      endcase
   endfunction

   task automatic run_op(input string tag, input logic [1:0] o, input int x,
                         input int c_qb, c_qc, c_q1, c_ln2, c_ln2i, c_m, c_bias,
                         input int sh, ob, hold);
      longint er, ee;
      int     lat, n;
      bit     idle_bad;
      model(o, x, c_qb, c_qc, c_q1, c_ln2, c_ln2i, c_m, c_bias, sh, ob, er, ee, lat);
      op = o; qin = x; qb = c_qb; qc = c_qc; q1 = c_q1;
      qln2 = c_ln2; qln2_inv = c_ln2i; m = c_m; bias = c_bias;
      shift = 8'(sh); out_bits = 6'(ob);
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 20) begin
         @(posedge clock); #1; n++;
      end
      if (!in_ready) begin
         chk({tag, ":accept_timeout"}, 0, 1);
         in_valid = 1'b0;
         return;
      end
      @(posedge clock); #1;
      in_valid = 1'b0;
      op = 2'($urandom); qin = $urandom; qb = $urandom; qc = $urandom; q1 = $urandom;
      qln2 = $urandom; qln2_inv = $urandom; m = $urandom; bias = $urandom;
      shift = 8'($urandom); out_bits = 6'($urandom);
      n = 0;
      idle_bad = 1'b0;
      while (!out_valid && n < 20) begin
         if (qout != 0 || err || in_ready) idle_bad = 1'b1;
         @(posedge clock); #1; n++;
      end
      chk({tag, ":latency"}, n, lat);
      chk({tag, ":busy_outputs"}, idle_bad, 0);
      chk({tag, ":qout"}, qout, er);
      chk({tag, ":err"}, err, ee);
      for (int k = 0; k < hold; k++) begin
         @(posedge clock); #1;
         chk({tag, ":hold_qout"}, qout, er);
         chk({tag, ":hold_valid"}, out_valid, 1);
         chk({tag, ":hold_in_ready"}, in_ready, 0);
      end
      out_ready = 1'b1;
      @(posedge clock); #1;
      out_ready = 1'b0;
      chk({tag, ":after_handshake"}, {out_valid, qout != 0, err, !in_ready}, 0);
   endtask

   initial begin
      int  o, x, c_qb, c_qc, c_q1, c_ln2, c_ln2i, c_m, c_bias, sh, ob;
      bit  stale;
      #2 reset_n = 1'b0;
      #10;
      chk("reset_out_valid", out_valid, 0);
      chk("reset_qout", qout, 0);
      chk("reset_err", err, 0);
      @(posedge clock); #1;
      reset_n = 1'b1;
      @(posedge clock); #1;
      chk("reset_in_ready", in_ready, 1);

      run_op("exp_q0",    2'd0, 0,    10, 5, 0, 50, 21474836, 0, 0, 0, 8, 0);
      run_op("exp_qm100", 2'd0, -100, 10, 5, 0, 50, 21474836, 0, 0, 0, 8, 1);
      run_op("gelu_q5",   2'd1, 5,   -10, 100, 200, 0, 0, 0, 0, 4, 8, 0);
      run_op("rq_pos_sat", 2'd2, 1000,  0, 0, 0, 0, 0, 3, 1, 2, 8, 0);
      run_op("rq_neg_sat", 2'd2, -1000, 0, 0, 0, 0, 0, 3, 1, 2, 8, 0);
      run_op("rq_bigshift", 2'd2, -5,   0, 0, 0, 0, 0, 1, 3, 200, 8, 0);
      run_op("rq_full_w",  2'd2, -7,    0, 0, 0, 0, 0, 9, 0, 1, 32, 0);
      run_op("illegal",    2'd3, 77,    1, 2, 3, 4, 5, 6, 7, 1, 8, 0);
      run_op("stall5",     2'd0, -100, 10, 5, 0, 50, 21474836, 0, 0, 0, 8, 5);

      // reset pulse in the middle of an exp
      op = 2'd0; qin = -100; qb = 10; qc = 5; qln2 = 50; qln2_inv = 21474836;
      in_valid = 1'b1;
      @(posedge clock); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clock);
      #2 reset_n = 1'b0;
      #1 chk("midreset_async_valid", out_valid, 0);
      #1 reset_n = 1'b1;
      @(posedge clock); #1;
      chk("midreset_in_ready", in_ready, 1);
      chk("midreset_out_valid", out_valid, 0);
      stale = 1'b0;
      repeat (12) begin
         @(posedge clock); #1;
         if (out_valid || qout != 0) stale = 1'b1;
      end
      chk("midreset_no_stale", stale, 0);
      run_op("post_reset", 2'd2, 40, 0, 0, 0, 0, 0, 5, -3, 1, 6, 0);

      for (int i = 0; i < 60; i++) begin
         o = int'($urandom_range(0, 3));
         if (o == 0) begin
            x      = -int'($urandom_range(0, 100000));
            c_ln2i = int'($urandom_range(0, 1 << 25));
            c_ln2  = int'($urandom_range(1, 2000));
            c_qb   = int'($urandom_range(0, 2000)) - 1000;
            c_qc   = int'($urandom_range(0, 2000)) - 1000;
         end else begin
            x      = $urandom;
            c_ln2i = $urandom;
            c_ln2  = $urandom;
            c_qb   = ($urandom_range(0, 1) == 0) ? $urandom : -int'($urandom_range(0, 5000));
            c_qc   = $urandom;
         end
         c_q1   = $urandom;
         c_m    = ($urandom_range(0, 1) == 0) ? $urandom : int'($urandom_range(0, 300)) - 150;
         c_bias = int'($urandom_range(0, 400)) - 200;
         sh     = ($urandom_range(0, 3) == 0) ? int'($urandom_range(64, 255))
                                              : int'($urandom_range(0, 40));
         ob     = int'($urandom_range(2, 32));
         run_op($sformatf("rand%0d_op%0d", i, o), 2'(o), x, c_qb, c_qc, c_q1, c_ln2,
                c_ln2i, c_m, c_bias, sh, ob, int'($urandom_range(0, 2)));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_err, n_chk);
      $fatal(1, "watchdog expired");
   end

endmodule
